// File: rtl/sm3_msg_expansion.sv
// SM3 message expansion / round sequencer feeding the compression function.
// Define SM3_ME_BYTE_SWAP_EN to byte-reverse each input word at acceptance.
module sm3_msg_expansion #(
  parameter int ROUNDS       = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         msg_valid_in,
  output logic         msg_ready_out,
  input  logic [511:0] msg_block_in,
  input  logic         msg_first_in,
  output logic         start_out,
  output logic [5:0]   index_j_out,
  output logic [31:0]  word_expanded_out,
  output logic [31:0]  word_expanded_p_out,
  output logic         is_1st_msg_block_out,
  output logic         busy_out,
  output logic         block_done_out
);

  typedef enum logic [2:0] {
    IDLE, PREP, START, LOAD, RUN, DRAIN, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] w_q [16];
  logic [31:0] w_new;
  logic        first_q;
  logic        live;
  logic        accept;
  logic        last_rnd;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] x);
`ifdef SM3_ME_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  assign live     = !reset_in;
  assign accept   = msg_valid_in && state_q == IDLE;
  assign last_rnd = cnt_q == 6'(ROUNDS - 1);

  assign w_new = p1(w_q[0] ^ w_q[7] ^ rotl(w_q[13], 15))
               ^ rotl(w_q[3], 7) ^ w_q[10];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (msg_valid_in) state_d = PREP;
      PREP:  state_d = START;
      START: state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (last_rnd) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DRAIN_CYCLES - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Final round does not shift, so w[0] keeps W63 visible through DRAIN.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      first_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++)
        w_q[i] <= ld(msg_block_in[511 - 32*i -: 32]);
      first_q <= msg_first_in;
    end else if (state_q == RUN && !last_rnd) begin
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
    end
  end

  assign msg_ready_out        = live && state_q == IDLE;
  assign start_out            = live && state_q == START;
  assign busy_out             = live && state_q != IDLE;
  assign block_done_out       = live && state_q == DONE;
  assign is_1st_msg_block_out = live && first_q;

  always_comb begin
    index_j_out         = '0;
    word_expanded_out   = '0;
    word_expanded_p_out = '0;
    if (live && state_q == RUN) begin
      index_j_out         = cnt_q;
      word_expanded_out   = w_q[0];
      word_expanded_p_out = w_q[0] ^ w_q[4];
    end else if (live && state_q == DRAIN) begin
      index_j_out         = 6'(ROUNDS - 1);
      word_expanded_out   = w_q[0];
      word_expanded_p_out = w_q[0] ^ w_q[4];
    end
  end

endmodule

// File: tb/tb_sm3_msg_expansion.sv
// Directed bench for sm3_msg_expansion with a behavioural SM3 compression
// model consuming the round interface to check chained digests.
module tb_sm3_msg_expansion;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic         msg_valid_in;
  logic         msg_ready_out;
  logic [511:0] msg_block_in;
  logic         msg_first_in;
  logic         start_out;
  logic [5:0]   index_j_out;
  logic [31:0]  word_expanded_out;
  logic [31:0]  word_expanded_p_out;
  logic         is_1st_msg_block_out;
  logic         busy_out;
  logic         block_done_out;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1  = {16{32'h61626364}};
  localparam logic [511:0] B2  = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] ABC_DIG =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] TWO_DIG =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  sm3_msg_expansion dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .msg_valid_in         (msg_valid_in),
    .msg_ready_out        (msg_ready_out),
    .msg_block_in         (msg_block_in),
    .msg_first_in         (msg_first_in),
    .start_out            (start_out),
    .index_j_out          (index_j_out),
    .word_expanded_out    (word_expanded_out),
    .word_expanded_p_out  (word_expanded_p_out),
    .is_1st_msg_block_out (is_1st_msg_block_out),
    .busy_out             (busy_out),
    .block_done_out       (block_done_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [511:0] bus(input logic [511:0] b);
    logic [511:0] r;
    r = b;
`ifdef SM3_ME_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++)
      r[32*i +: 32] = {b[32*i +: 8], b[32*i+8 +: 8],
                       b[32*i+16 +: 8], b[32*i+24 +: 8]};
`endif
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  // Compression-function model driven by the DUT round interface
  logic [31:0] iv  [8] = '{32'h7380166f, 32'h4914b2b9, 32'h172442d7,
                           32'hda8a0600, 32'ha96f30bc, 32'h163138aa,
                           32'he38dee4d, 32'hb0fb0e4e};
  logic [31:0] v   [8];
  logic [31:0] vin [8];
  logic [31:0] r   [8];
  logic [31:0] tj, ss1, ss2, ff, gg, tt1, tt2;
  int rcnt = 99;
  int start_cnt = 0;
  bit idx_bad = 0;

  initial for (int i = 0; i < 8; i++) v[i] = iv[i];

  always @(negedge clk_in) begin
    if (reset_in === 1'b1) begin
      rcnt = 99;
    end else if (start_out === 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        vin[i] = is_1st_msg_block_out ? iv[i] : v[i];
        r[i]   = vin[i];
      end
      rcnt = -1;
      start_cnt++;
    end else if (rcnt == -1) begin
      rcnt = 0;
    end else if (rcnt >= 0 && rcnt < 64) begin
      if (index_j_out !== 6'(rcnt)) idx_bad = 1;
      tj  = rcnt < 16 ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(r[0], 12) + r[4] + rotl(tj, rcnt), 7);
      ss2 = ss1 ^ rotl(r[0], 12);
      ff  = rcnt < 16 ? r[0] ^ r[1] ^ r[2]
                      : (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
      gg  = rcnt < 16 ? r[4] ^ r[5] ^ r[6]
                      : (r[4] & r[5]) | (~r[4] & r[6]);
      tt1 = ff + r[3] + ss2 + word_expanded_p_out;
      tt2 = gg + r[7] + ss1 + word_expanded_out;
      r[3] = r[2];
      r[2] = rotl(r[1], 9);
      r[1] = r[0];
      r[0] = tt1;
      r[7] = r[6];
      r[6] = rotl(r[5], 19);
      r[5] = r[4];
      r[4] = tt2 ^ rotl(tt2, 9) ^ rotl(tt2, 17);
      rcnt++;
      if (rcnt == 64)
        for (int i = 0; i < 8; i++) v[i] = vin[i] ^ r[i];
    end
  end

  function automatic logic [255:0] digest();
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  task automatic test_reset();
    logic [44:0] outs;
    reset_in     = 1'b1;
    msg_valid_in = 1'b1;
    msg_first_in = 1'b1;
    msg_block_in = bus(ABC);
    repeat (3) begin
      @(negedge clk_in);
      outs = {msg_ready_out, start_out, index_j_out, word_expanded_out,
              is_1st_msg_block_out, busy_out, block_done_out,
              word_expanded_p_out[1:0]};
      checks++;
      if (outs !== '0 || word_expanded_p_out !== '0) begin
        errors++;
        $display("FAIL reset_outs: got %h required 0", outs);
      end
    end
    reset_in     = 1'b0;
    msg_valid_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (msg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready %b busy %b required 1 0",
               msg_ready_out, busy_out);
    end
  endtask

  task automatic test_abc();
    logic [31:0] wl, wpl;
    @(negedge clk_in);
    msg_block_in = bus(ABC);
    msg_first_in = 1'b1;
    msg_valid_in = 1'b1;
    checks++;
    if (msg_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL abc_ready: got %b required 1", msg_ready_out);
    end
    @(negedge clk_in);
    msg_valid_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || start_out !== 1'b0 ||
        is_1st_msg_block_out !== 1'b1) begin
      errors++;
      $display("FAIL abc_prep: busy %b start %b first %b required 1 0 1",
               busy_out, start_out, is_1st_msg_block_out);
    end
    @(negedge clk_in);
    checks++;
    if (start_out !== 1'b1 || index_j_out !== 6'd0) begin
      errors++;
      $display("FAIL abc_start: start %b idx %0d required 1 0",
               start_out, index_j_out);
    end
    @(negedge clk_in);
    checks++;
    if (start_out !== 1'b0 || index_j_out !== 6'd0) begin
      errors++;
      $display("FAIL abc_load: start %b idx %0d required 0 0",
               start_out, index_j_out);
    end
    @(negedge clk_in);
    checks++;
    if (index_j_out !== 6'd0 || word_expanded_out !== 32'h61626380 ||
        word_expanded_p_out !== 32'h61626380) begin
      errors++;
      $display("FAIL abc_round0: idx %0d w %h wp %h required 0 61626380 61626380",
               index_j_out, word_expanded_out, word_expanded_p_out);
    end
    repeat (16) @(negedge clk_in);
    checks++;
    if (index_j_out !== 6'd16 || word_expanded_out !== 32'h9092e200) begin
      errors++;
      $display("FAIL abc_round16: idx %0d w %h required 16 9092e200",
               index_j_out, word_expanded_out);
    end
    repeat (47) @(negedge clk_in);
    wl  = word_expanded_out;
    wpl = word_expanded_p_out;
    checks++;
    if (index_j_out !== 6'd63) begin
      errors++;
      $display("FAIL abc_round63: idx %0d required 63", index_j_out);
    end
    @(negedge clk_in);
    checks++;
    if (index_j_out !== 6'd63 || word_expanded_out !== wl ||
        word_expanded_p_out !== wpl || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL abc_drain: idx %0d w %h wp %h required 63 %h %h",
               index_j_out, word_expanded_out, word_expanded_p_out, wl, wpl);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (block_done_out !== 1'b1 || digest() !== ABC_DIG || idx_bad) begin
      errors++;
      $display("FAIL abc_done: done %b idx_bad %b digest %h required 1 0 %h",
               block_done_out, idx_bad, digest(), ABC_DIG);
    end
    @(negedge clk_in);
    checks++;
    if (msg_ready_out !== 1'b1 || busy_out !== 1'b0 ||
        block_done_out !== 1'b0) begin
      errors++;
      $display("FAIL abc_idle: ready %b busy %b done %b required 1 0 0",
               msg_ready_out, busy_out, block_done_out);
    end
  endtask

  task automatic test_two_block();
    int n;
    @(negedge clk_in);
    msg_block_in = bus(B1);
    msg_first_in = 1'b1;
    msg_valid_in = 1'b1;
    @(negedge clk_in);
    msg_block_in = bus(B2);
    msg_first_in = 1'b0;
    n = 1;
    while (block_done_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n != 70 || msg_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL two_done1: cycles %0d ready %b required 70 0",
               n, msg_ready_out);
    end
    @(negedge clk_in);
    checks++;
    if (msg_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL two_accept2: ready %b required 1", msg_ready_out);
    end
    @(negedge clk_in);
    msg_valid_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || is_1st_msg_block_out !== 1'b0) begin
      errors++;
      $display("FAIL two_prep2: busy %b first %b required 1 0",
               busy_out, is_1st_msg_block_out);
    end
    n = 1;
    while (block_done_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n != 70 || digest() !== TWO_DIG) begin
      errors++;
      $display("FAIL two_digest: cycles %0d digest %h required 70 %h",
               n, digest(), TWO_DIG);
    end
  endtask

  task automatic test_handshake();
    int n;
    int sc0;
    bit rdy_seen;
    @(negedge clk_in);
    msg_block_in = bus(ABC);
    msg_first_in = 1'b1;
    msg_valid_in = 1'b1;
    @(negedge clk_in);
    msg_valid_in = 1'b0;
    sc0 = start_cnt;
    repeat (10) @(negedge clk_in);
    rdy_seen = 0;
    msg_block_in = bus(B1);
    msg_first_in = 1'b0;
    repeat (5) begin
      msg_valid_in = 1'b1;
      @(negedge clk_in);
      if (msg_ready_out !== 1'b0) rdy_seen = 1;
      msg_valid_in = 1'b0;
      @(negedge clk_in);
    end
    checks++;
    if (rdy_seen || is_1st_msg_block_out !== 1'b1) begin
      errors++;
      $display("FAIL hs_ignored: ready_seen %b first %b required 0 1",
               rdy_seen, is_1st_msg_block_out);
    end
    n = 0;
    while (block_done_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n >= 200 || start_cnt != sc0 + 1 || idx_bad) begin
      errors++;
      $display("FAIL hs_sequence: wait %0d starts %0d idx_bad %b required <200 %0d 0",
               n, start_cnt - sc0, idx_bad, 1);
    end
    checks++;
    if (digest() !== ABC_DIG) begin
      errors++;
      $display("FAIL hs_digest: got %h required %h", digest(), ABC_DIG);
    end
  endtask

  task automatic test_reset_mid();
    logic [44:0] outs;
    bit seen;
    int n;
    @(negedge clk_in);
    msg_block_in = bus(ABC);
    msg_first_in = 1'b1;
    msg_valid_in = 1'b1;
    @(negedge clk_in);
    msg_valid_in = 1'b0;
    repeat (33) @(negedge clk_in);
    checks++;
    if (index_j_out !== 6'd30) begin
      errors++;
      $display("FAIL rmid_idx: got %0d required 30", index_j_out);
    end
    reset_in = 1'b1;
    @(negedge clk_in);
    outs = {msg_ready_out, start_out, index_j_out, word_expanded_out,
            is_1st_msg_block_out, busy_out, block_done_out,
            word_expanded_p_out[1:0]};
    checks++;
    if (outs !== '0 || word_expanded_p_out !== '0) begin
      errors++;
      $display("FAIL rmid_outs: got %h required 0", outs);
    end
    reset_in = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk_in);
      if (block_done_out !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || msg_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_nodone: done_seen %b ready %b required 0 1",
               seen, msg_ready_out);
    end
    msg_block_in = bus(ABC);
    msg_first_in = 1'b1;
    msg_valid_in = 1'b1;
    @(negedge clk_in);
    msg_valid_in = 1'b0;
    n = 1;
    while (block_done_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n != 70 || digest() !== ABC_DIG) begin
      errors++;
      $display("FAIL rmid_digest: cycles %0d digest %h required 70 %h",
               n, digest(), ABC_DIG);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
